fp32_rx_frame_ctrl: RTL

FP32_RX_FRAME_CTRL -- requirements
Module: fp32_rx_frame_ctrl

---
 rtl/fp32_rx_frame_ctrl_if.sv | 26 ++
 rtl/fp32_rx_frame_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fp32_rx_frame_ctrl_if.sv
// Byte-in / frame-out bundle for the fp32 frame controller.
// "master" is the controller side (drives byte_ready and the frame outputs);
// "slave" is the environment (byte receiver plus frame consumer).
interface fp32_rx_frame_ctrl_if #(
  parameter int NUM_BYTES = 12
);
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     frame_valid;
  logic                     frame_ready;
  logic [8*NUM_BYTES-1:0]   frame_data;
  logic                     timeout;
  logic                     overrun;
  logic [15:0]              frame_cnt;

  modport master (
    input  byte_valid, byte_data, frame_ready,
    output byte_ready, frame_valid, frame_data, timeout, overrun, frame_cnt
  );

  modport slave (
    output byte_valid, byte_data, frame_ready,
    input  byte_ready, frame_valid, frame_data, timeout, overrun, frame_cnt
  );
endinterface

// File: rtl/fp32_rx_frame_ctrl.sv
// Assembles NUM_BYTES received bytes (little-endian) into one frame, holds it
// until the consumer takes it, and discards partial frames after an idle gap.
module fp32_rx_frame_ctrl #(
  parameter int NUM_BYTES    = 12,
  parameter int TIMEOUT_CLKS = 104160
) (
  input  logic                 CLK_I,
  input  logic                 RSTL_I,
  fp32_rx_frame_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]    LAST_IDX = 4'(NUM_BYTES - 1);

  logic [1:0]    state_reg, state_next;
  logic [3:0]    idx_reg, idx_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          timeout_reg, timeout_next;
  logic          overrun_reg, overrun_next;
  logic          byte_ready_reg;
  logic [15:0]   frame_cnt_reg;
  logic          wr_en;
  logic [3:0]    wr_idx;
  logic          handshake;

  // A frame leaves only while held and the consumer is ready.
  assign handshake = (state_reg == ST_HOLD) && bus.frame_ready;

  // Next-state, byte write strobe and pulse generation.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    tmo_next     = tmo_reg;
    timeout_next = 1'b0;
    overrun_next = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.byte_valid) begin
          wr_en      = 1'b1;
          wr_idx     = 4'd0;
          idx_next   = 4'd1;
          tmo_next   = '0;
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // An arriving byte always wins over an expiring timeout.
        if (bus.byte_valid) begin
          wr_en    = 1'b1;
          idx_next = idx_reg + 4'd1;
          tmo_next = '0;
          if (idx_reg == LAST_IDX) begin
            state_next = ST_HOLD;
          end
        end else if (tmo_reg == TMO_LAST) begin
          timeout_next = 1'b1;
          idx_next     = 4'd0;
          tmo_next     = '0;
          state_next   = ST_IDLE;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end
      ST_HOLD: begin
        if (bus.frame_ready) begin
          // A byte arriving on the handoff cycle starts the next frame.
          if (bus.byte_valid) begin
            wr_en      = 1'b1;
            wr_idx     = 4'd0;
            idx_next   = 4'd1;
            tmo_next   = '0;
            state_next = ST_COLLECT;
          end else begin
            idx_next   = 4'd0;
            state_next = ST_IDLE;
          end
        end else if (bus.byte_valid) begin
          overrun_next = 1'b1;
        end
      end
      default: begin
        idx_next   = 4'd0;
        tmo_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Control state, index, idle counter and status pulses.
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= 4'd0;
      tmo_reg        <= '0;
      timeout_reg    <= 1'b0;
      overrun_reg    <= 1'b0;
      byte_ready_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      tmo_reg        <= tmo_next;
      timeout_reg    <= timeout_next;
      overrun_reg    <= overrun_next;
      byte_ready_reg <= (state_next != ST_HOLD);
    end
  end

  // Handoff counter, only touched on a handshake so it wraps naturally.
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      frame_cnt_reg <= 16'd0;
    end else if (handshake) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  // One register per frame byte; unwritten bytes keep their old contents.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
      logic [7:0] byte_reg;

      // Capture the incoming byte when it targets this slot.
      always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
          byte_reg <= 8'd0;
        end else if (wr_en && (wr_idx == 4'(gi))) begin
          byte_reg <= bus.byte_data;
        end
      end

      assign bus.frame_data[8*gi +: 8] = byte_reg;
    end
  endgenerate

  assign bus.byte_ready  = byte_ready_reg;
  assign bus.frame_valid = (state_reg == ST_HOLD);
  assign bus.timeout     = timeout_reg;
  assign bus.overrun     = overrun_reg;
  assign bus.frame_cnt   = frame_cnt_reg;

endmodule
